// File: rtl/dsmc_dram_writer.sv
// dsmc_dram_writer: packs 16-bit ADC sample pairs into RAM words and fills
// ping-pong halves of the DSMC buffer RAM, flagging each full half to the host.
module dsmc_dram_writer #(
    parameter int unsigned WR_ADDR_WIDTH = 14,
    parameter int unsigned WR_DATA_WIDTH = 32,
    parameter int unsigned SAMPLE_WIDTH  = 16
) (
    input  logic                     wr_clk,
    input  logic                     wr_rst,
    input  logic                     enable,
    input  logic                     s_valid,
    input  logic [SAMPLE_WIDTH-1:0]  s_data,
    output logic                     s_ready,
    output logic [WR_ADDR_WIDTH-1:0] wr_addr,
    output logic [WR_DATA_WIDTH-1:0] wr_data,
    output logic                     wr_en,
    output logic [1:0]               buf_ready,
    output logic                     buf_done,
    input  logic [1:0]               buf_ack,
    output logic                     overflow,
    input  logic                     overflow_clr
);

    localparam int unsigned IDX_W = WR_ADDR_WIDTH - 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]               state_q, state_d;
    logic                     half_q, half_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     phase_q, phase_d;
    logic [SAMPLE_WIDTH-1:0]  low_q, low_d;

    logic                     wr_en_d;
    logic [WR_ADDR_WIDTH-1:0] wr_addr_d;
    logic [WR_DATA_WIDTH-1:0] wr_data_d;
    logic [1:0]               buf_ready_d;
    logic                     buf_done_d;
    logic                     overflow_d;

    logic                     accept;
    logic                     word_wr;
    logic                     last_word;
    logic [1:0]               set_vec;

    // Samples are only taken while filling
    assign s_ready = (state_q == ST_FILL);

    // Next-state, packing, flag and write-port logic
    always_comb begin
        state_d     = state_q;
        half_d      = half_q;
        idx_d       = idx_q;
        phase_d     = phase_q;
        low_d       = low_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr;
        wr_data_d   = wr_data;
        buf_done_d  = 1'b0;
        overflow_d  = overflow;
        set_vec     = 2'b00;

        accept    = s_ready && s_valid;
        word_wr   = accept && phase_q;
        last_word = word_wr && (idx_q == '1);

        if (last_word) begin
            set_vec = half_q ? 2'b10 : 2'b01;
        end
        // Set wins over a same-cycle ack of the same bit
        buf_ready_d = (buf_ready & ~buf_ack) | set_vec;

        if (accept) begin
            if (!phase_q) begin
                low_d   = s_data;
                phase_d = 1'b1;
            end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = {half_q, idx_q};
                wr_data_d = WR_DATA_WIDTH'({s_data, low_q});
                phase_d   = 1'b0;
                idx_d     = idx_q + IDX_W'(1);
            end
        end

        if (last_word) begin
            half_d     = ~half_q;
            buf_done_d = 1'b1;
        end

        // A sample offered while stalled is lost; set beats clear
        if ((state_q == ST_WAIT) && s_valid) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                idx_d   = '0;
                phase_d = 1'b0;
                if (enable) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (last_word && buf_ready_d[half_d]) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (!buf_ready[half_q]) begin
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state_q   <= ST_IDLE;
            half_q    <= 1'b0;
            idx_q     <= '0;
            phase_q   <= 1'b0;
            low_q     <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            buf_ready <= 2'b00;
            buf_done  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state_q   <= state_d;
            half_q    <= half_d;
            idx_q     <= idx_d;
            phase_q   <= phase_d;
            low_q     <= low_d;
            wr_en     <= wr_en_d;
            wr_addr   <= wr_addr_d;
            wr_data   <= wr_data_d;
            buf_ready <= buf_ready_d;
            buf_done  <= buf_done_d;
            overflow  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_dsmc_dram_writer.sv
// Directed bench for dsmc_dram_writer with 4 words per half.
module tb_dsmc_dram_writer;

    logic        wr_clk;
    logic        wr_rst;
    logic        enable;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic [1:0]  buf_ready;
    logic        buf_done;
    logic [1:0]  buf_ack;
    logic        overflow;
    logic        overflow_clr;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_row  = 0;

    typedef struct {
        logic        rst;
        logic        en;
        logic        v;
        logic [15:0] d;
        logic [1:0]  ack;
        logic        oclr;
        logic        e_srdy;
        logic        e_wen;
        logic [2:0]  e_addr;
        logic [31:0] e_data;
        logic [1:0]  e_rdy;
        logic        e_done;
        logic        e_ovf;
    } vec_t;

    vec_t vq[$];

    // Last written address/data: outputs must hold these between writes
    logic [2:0]  hold_addr;
    logic [31:0] hold_data;

    dsmc_dram_writer #(
        .WR_ADDR_WIDTH(3),
        .WR_DATA_WIDTH(32),
        .SAMPLE_WIDTH(16)
    ) dut (
        .wr_clk(wr_clk),
        .wr_rst(wr_rst),
        .enable(enable),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_ready(s_ready),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_en(wr_en),
        .buf_ready(buf_ready),
        .buf_done(buf_done),
        .buf_ack(buf_ack),
        .overflow(overflow),
        .overflow_clr(overflow_clr)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    function automatic void add(input logic rst, input logic en, input logic v,
                                input logic [15:0] d, input logic [1:0] ack,
                                input logic oclr, input logic srdy, input logic wen,
                                input logic [2:0] addr, input logic [31:0] data,
                                input logic [1:0] rdy, input logic done,
                                input logic ovf);
        vec_t r;
        r.rst = rst; r.en = en; r.v = v; r.d = d; r.ack = ack; r.oclr = oclr;
        r.e_srdy = srdy; r.e_wen = wen; r.e_addr = addr; r.e_data = data;
        r.e_rdy = rdy; r.e_done = done; r.e_ovf = ovf;
        vq.push_back(r);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row=%0d actual=%h expected=%h", name, cur_row, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic en, input logic v,
                         input logic [15:0] d, input logic [1:0] ack, input logic oclr);
        @(negedge wr_clk);
        wr_rst = rst; enable = en; s_valid = v; s_data = d;
        buf_ack = ack; overflow_clr = oclr;
        @(posedge wr_clk);
        #1;
    endtask

    task automatic check_all(input logic srdy, input logic wen, input logic [2:0] addr,
                             input logic [31:0] data, input logic [1:0] rdy,
                             input logic done, input logic ovf);
        check("s_ready",   32'(s_ready),   32'(srdy));
        check("wr_en",     32'(wr_en),     32'(wen));
        check("wr_addr",   32'(wr_addr),   32'(addr));
        check("wr_data",   wr_data,        data);
        check("buf_ready", 32'(buf_ready), 32'(rdy));
        check("buf_done",  32'(buf_done),  32'(done));
        check("overflow",  32'(overflow),  32'(ovf));
    endtask

    initial begin
        wr_rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0;
        buf_ack = 2'b00; overflow_clr = 1'b0;
        hold_addr = '0; hold_data = '0;

        //   rst en v  data    ack   oclr srdy wen addr data          rdy   done ovf
        add(1, 0, 0, 16'h0,  2'b00, 0,   0,  0,  0, 32'h0,        2'b00, 0, 0);
        add(0, 1, 0, 16'h0,  2'b00, 0,   1,  0,  0, 32'h0,        2'b00, 0, 0);
        // Half 0 fill, samples 1..8
        add(0, 1, 1, 16'h1,  2'b00, 0,   1,  0,  0, 32'h0,        2'b00, 0, 0);
        add(0, 1, 1, 16'h2,  2'b00, 0,   1,  1,  0, 32'h00020001, 2'b00, 0, 0);
        add(0, 1, 1, 16'h3,  2'b00, 0,   1,  0,  0, 32'h0,        2'b00, 0, 0);
        add(0, 1, 1, 16'h4,  2'b00, 0,   1,  1,  1, 32'h00040003, 2'b00, 0, 0);
        add(0, 1, 1, 16'h5,  2'b00, 0,   1,  0,  0, 32'h0,        2'b00, 0, 0);
        add(0, 1, 1, 16'h6,  2'b00, 0,   1,  1,  2, 32'h00060005, 2'b00, 0, 0);
        add(0, 1, 1, 16'h7,  2'b00, 0,   1,  0,  0, 32'h0,        2'b00, 0, 0);
        add(0, 1, 1, 16'h8,  2'b00, 0,   1,  1,  3, 32'h00080007, 2'b01, 1, 0);
        // Half 1 fill with no ack, ends in WAIT
        add(0, 1, 1, 16'h9,  2'b00, 0,   1,  0,  0, 32'h0,        2'b01, 0, 0);
        add(0, 1, 1, 16'hA,  2'b00, 0,   1,  1,  4, 32'h000A0009, 2'b01, 0, 0);
        add(0, 1, 1, 16'hB,  2'b00, 0,   1,  0,  0, 32'h0,        2'b01, 0, 0);
        add(0, 1, 1, 16'hC,  2'b00, 0,   1,  1,  5, 32'h000C000B, 2'b01, 0, 0);
        add(0, 1, 1, 16'hD,  2'b00, 0,   1,  0,  0, 32'h0,        2'b01, 0, 0);
        add(0, 1, 1, 16'hE,  2'b00, 0,   1,  1,  6, 32'h000E000D, 2'b01, 0, 0);
        add(0, 1, 1, 16'hF,  2'b00, 0,   1,  0,  0, 32'h0,        2'b01, 0, 0);
        add(0, 1, 1, 16'h10, 2'b00, 0,   0,  1,  7, 32'h0010000F, 2'b11, 1, 0);
        // Offers during WAIT raise overflow, nothing written
        add(0, 1, 1, 16'h55, 2'b00, 0,   0,  0,  0, 32'h0,        2'b11, 0, 1);
        add(0, 1, 1, 16'h56, 2'b00, 0,   0,  0,  0, 32'h0,        2'b11, 0, 1);
        add(0, 1, 1, 16'h57, 2'b00, 0,   0,  0,  0, 32'h0,        2'b11, 0, 1);
        // Host releases half 0; FILL resumes two cycles after the ack
        add(0, 1, 0, 16'h0,  2'b01, 0,   0,  0,  0, 32'h0,        2'b10, 0, 1);
        add(0, 1, 0, 16'h0,  2'b00, 0,   1,  0,  0, 32'h0,        2'b10, 0, 1);
        // Ack of a clear flag is a no-op; overflow_clr alone clears
        add(0, 1, 1, 16'h11, 2'b01, 1,   1,  0,  0, 32'h0,        2'b10, 0, 0);
        add(0, 1, 1, 16'h12, 2'b00, 0,   1,  1,  0, 32'h00120011, 2'b10, 0, 0);
        add(0, 1, 1, 16'h13, 2'b00, 0,   1,  0,  0, 32'h0,        2'b10, 0, 0);
        add(0, 1, 1, 16'h14, 2'b00, 0,   1,  1,  1, 32'h00140013, 2'b10, 0, 0);
        add(0, 1, 1, 16'h15, 2'b00, 0,   1,  0,  0, 32'h0,        2'b10, 0, 0);
        add(0, 1, 1, 16'h16, 2'b00, 0,   1,  1,  2, 32'h00160015, 2'b10, 0, 0);
        add(0, 1, 1, 16'h17, 2'b10, 0,   1,  0,  0, 32'h0,        2'b00, 0, 0);
        // Ack of bit 0 in the completing cycle: set wins; half 1 free, stay in FILL
        add(0, 1, 1, 16'h18, 2'b01, 0,   1,  1,  3, 32'h00180017, 2'b01, 1, 0);
        // Half 1: one word, then a dangling sample lost to enable drop
        add(0, 1, 1, 16'h21, 2'b00, 0,   1,  0,  0, 32'h0,        2'b01, 0, 0);
        add(0, 1, 1, 16'h22, 2'b00, 0,   1,  1,  4, 32'h00220021, 2'b01, 0, 0);
        add(0, 1, 1, 16'h23, 2'b00, 0,   1,  0,  0, 32'h0,        2'b01, 0, 0);
        add(0, 0, 0, 16'h0,  2'b00, 0,   0,  0,  0, 32'h0,        2'b01, 0, 0);
        add(0, 1, 0, 16'h0,  2'b00, 0,   1,  0,  0, 32'h0,        2'b01, 0, 0);
        add(0, 1, 1, 16'hA0, 2'b00, 0,   1,  0,  0, 32'h0,        2'b01, 0, 0);
        add(0, 1, 1, 16'hA1, 2'b00, 0,   1,  1,  4, 32'h00A100A0, 2'b01, 0, 0);
        // Second-of-pair accepted as enable falls still writes
        add(0, 1, 1, 16'hB0, 2'b00, 0,   1,  0,  0, 32'h0,        2'b01, 0, 0);
        add(0, 0, 1, 16'hB1, 2'b00, 0,   0,  1,  5, 32'h00B100B0, 2'b01, 0, 0);
        // IDLE ignores samples and does not flag overflow
        add(0, 0, 1, 16'hC0, 2'b00, 0,   0,  0,  0, 32'h0,        2'b01, 0, 0);
        add(0, 1, 0, 16'h0,  2'b00, 0,   1,  0,  0, 32'h0,        2'b01, 0, 0);
        // Refill half 1 from index 0; half 0 still unread so go to WAIT
        add(0, 1, 1, 16'h31, 2'b00, 0,   1,  0,  0, 32'h0,        2'b01, 0, 0);
        add(0, 1, 1, 16'h32, 2'b00, 0,   1,  1,  4, 32'h00320031, 2'b01, 0, 0);
        add(0, 1, 1, 16'h33, 2'b00, 0,   1,  0,  0, 32'h0,        2'b01, 0, 0);
        add(0, 1, 1, 16'h34, 2'b00, 0,   1,  1,  5, 32'h00340033, 2'b01, 0, 0);
        add(0, 1, 1, 16'h35, 2'b00, 0,   1,  0,  0, 32'h0,        2'b01, 0, 0);
        add(0, 1, 1, 16'h36, 2'b00, 0,   1,  1,  6, 32'h00360035, 2'b01, 0, 0);
        add(0, 1, 1, 16'h37, 2'b00, 0,   1,  0,  0, 32'h0,        2'b01, 0, 0);
        add(0, 1, 1, 16'h38, 2'b00, 0,   0,  1,  7, 32'h00380037, 2'b11, 1, 0);
        // Overflow set beats overflow_clr, then clr alone clears
        add(0, 1, 1, 16'h99, 2'b00, 1,   0,  0,  0, 32'h0,        2'b11, 0, 1);
        add(0, 1, 0, 16'h0,  2'b00, 1,   0,  0,  0, 32'h0,        2'b11, 0, 0);
        // enable=0 in WAIT returns to IDLE, flags kept
        add(0, 0, 0, 16'h0,  2'b00, 0,   0,  0,  0, 32'h0,        2'b11, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            cur_row = i;
            drive(vq[i].rst, vq[i].en, vq[i].v, vq[i].d, vq[i].ack, vq[i].oclr);
            if (vq[i].rst || vq[i].e_wen) begin
                hold_addr = vq[i].e_addr;
                hold_data = vq[i].e_data;
            end
            check_all(vq[i].e_srdy, vq[i].e_wen, hold_addr, hold_data,
                      vq[i].e_rdy, vq[i].e_done, vq[i].e_ovf);
        end

        // Reset mid-half: five samples into half 0, then reset with inputs active
        cur_row = 1000;
        drive(0, 1, 0, 16'h0, 2'b00, 0);
        check("seq_fill_srdy", 32'(s_ready), 32'd1);
        drive(0, 1, 1, 16'h41, 2'b00, 0);
        drive(0, 1, 1, 16'h42, 2'b00, 0);
        check("seq_w0_addr", 32'(wr_addr), 32'd0);
        check("seq_w0_data", wr_data, 32'h00420041);
        drive(0, 1, 1, 16'h43, 2'b00, 0);
        drive(0, 1, 1, 16'h44, 2'b00, 0);
        drive(0, 1, 1, 16'h45, 2'b00, 0);
        cur_row = 1001;
        drive(1, 1, 1, 16'h46, 2'b00, 0);
        check_all(0, 0, 3'd0, 32'h0, 2'b00, 0, 0);
        cur_row = 1002;
        drive(0, 1, 0, 16'h0, 2'b00, 0);
        check_all(1, 0, 3'd0, 32'h0, 2'b00, 0, 0);
        drive(0, 1, 1, 16'hD1, 2'b00, 0);
        check("seq_rst_wen0", 32'(wr_en), 32'd0);
        drive(0, 1, 1, 16'hD2, 2'b00, 0);
        cur_row = 1003;
        check_all(1, 1, 3'd0, 32'h00D200D1, 2'b00, 0, 0);
        drive(0, 0, 0, 16'h0, 2'b00, 0);
        check("seq_idle_srdy", 32'(s_ready), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dsmc_dram_writer.md
Name: dsmc_dram_writer

Overview:
- Producer-side companion to the DSMC dual-port buffer RAM.
- Accepts a stream of 16-bit ADC samples, packs sample pairs into 32-bit words and drives the RAM write port.
- Uses ping-pong halves of the address space. Raises a per-half ready flag when a half is full so the host can read it over DSMC, then clear it.
- Sits between the ADC capture front end and the RAM write port, in the write-clock domain.

Parameters:
- WR_ADDR_WIDTH, 14: RAM write address width. Bit [WR_ADDR_WIDTH-1] selects the half; the lower bits are the word index. Minimum 2.
- WR_DATA_WIDTH, 32: RAM word width. Must equal 2*SAMPLE_WIDTH.
- SAMPLE_WIDTH, 16: ADC sample width.

Ports:
- wr_clk  in  1  sole clock; all logic on rising edge.
- wr_rst  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = capture running, 0 = stop and return to IDLE.
- s_valid  in  1  sample valid.
- s_data  in  SAMPLE_WIDTH  sample.
- s_ready  out  1  sample accepted when s_valid & s_ready.
- wr_addr  out  WR_ADDR_WIDTH  RAM write address.
- wr_data  out  WR_DATA_WIDTH  RAM write data, {second sample, first sample}.
- wr_en  out  1  RAM write strobe, one cycle per word.
- buf_ready  out  2  level flag per half; bit h = half h full and unread.
- buf_done  out  1  one-cycle pulse when any half completes.
- buf_ack  in  2  host clear; bit h clears buf_ready[h].
- overflow  out  1  sticky; a sample was offered while capture was stalled.
- overflow_clr  in  1  clears overflow.

Behaviour:
- Reset (wr_rst=1 at clock edge): state=IDLE.
  - All outputs 0: s_ready, wr_en, wr_addr, wr_data, buf_ready, buf_done, overflow.
  - Internal state cleared: half pointer, word index, pack phase.
- Reset wins over every other input in the same cycle. Reset mid-half discards the partial word and any pending flags.
- States: IDLE, FILL, WAIT.
  - IDLE: s_ready=0. On enable=1, go to FILL with word index 0 and pack phase 0. The half pointer keeps its value; it is 0 after reset.
  - FILL: s_ready=1 combinationally (s_ready = state==FILL).
    - Accept with phase 0: latch the sample into the low holding register and set phase to 1.
    - Accept with phase 1: register wr_en=1, wr_data={s_data, low}, wr_addr={half, index}. These appear the cycle after acceptance (latency 1). Set phase to 0 and increment the index.
    - Word write of index 2^(WR_ADDR_WIDTH-1)-1 (last word of the half):
      - in the same registered cycle as that wr_en: set buf_ready[half] and pulse buf_done;
      - toggle the half pointer and reset the index to 0;
      - if buf_ready[new half] is already 1 (after this cycle's ack), go to WAIT; otherwise stay in FILL with no gap cycle.
  - WAIT: s_ready=0. Any s_valid=1 cycle sets overflow. Go to FILL on the cycle after buf_ready[current half] becomes 0. No samples are stored while in WAIT.
- enable=0 in FILL or WAIT: go to IDLE on the next edge.
  - A half-packed word is discarded. The index resets to 0 on re-enable; the half pointer is kept.
  - buf_ready flags are kept.
  - A sample accepted in the same cycle as enable falls is processed normally. The word write completes if it was the second of a pair.
- buf_ready[h] clears on buf_ack[h]=1 in any state.
  - Ack of a flag that is already 0: no effect.
  - Ack and set of the same bit in the same cycle: set wins.
- overflow: set has priority over overflow_clr in the same cycle.
- wr_en is never asserted outside word writes. wr_addr and wr_data hold their last values while wr_en=0.
- The index wraps only via the half switch. An address never exceeds its half.

Test Plan (WR_ADDR_WIDTH=3, so 4 words/half and 8 samples/half):
- Reset then enable=1, s_valid=1 with continuous samples 0x0001..0x0008 → wr_en 1 at cycles 2,4,6,8 after the first acceptance. wr_addr 0,1,2,3; wr_data 0x00020001, 0x00040003, 0x00060005, 0x00080007. buf_ready=01 and buf_done pulses with the addr-3 write.
- Continue with samples 0x0009..0x0010 and no ack → half 1 filled at addr 4..7, buf_ready=11, state WAIT, s_ready=0. Then s_valid=1 for 3 cycles → overflow=1 and no wr_en.
- From WAIT, pulse buf_ack=01 → s_ready=1 two cycles later; next words write addr 0..3. buf_ready[1] stays 1.
- Three samples, then enable=0 for 1 cycle, then enable=1 and samples 0xA0,0xA1 → the third sample is dropped; write {0x00A1,0x00A0} at the next word index 0 of the current half.
- buf_ack[0] asserted in the same cycle half 0 completes → buf_ready[0]=1 (set wins). overflow_clr together with an overflow event → overflow stays 1.
- Assert wr_rst mid-half after 5 samples → next-cycle outputs all 0. After enable, the first write goes to addr 0 with no stale data.
